dram_sequencer: RTL

DRAM_SEQUENCER -- requirements
Module: dram_sequencer

---
 rtl/dram_seq_pkg.sv | 24 ++
 rtl/dram_refresh_timer.sv | 35 +++
 rtl/dram_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dram_seq_pkg.sv
// Shared types and address-split constants for the 16K x 1 DRAM sequencer.
package dram_seq_pkg;

  localparam int ROW_W  = 7;
  localparam int COL_W  = 7;
  localparam int ADDR_W = 14;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    CAS,
    DONE,
    PRE,
    RROW
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU
  } owner_t;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh timer, single-entry pending flag and 7-bit refresh row counter.
module dram_refresh_timer
  import dram_seq_pkg::*;
#(
  parameter int REFRESH_PERIOD = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             row_inc,
  output logic             pending,
  output logic [ROW_W-1:0] row
);

  logic [9:0] tmr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr     <= '0;
      pending <= 1'b0;
      row     <= '0;
    end else begin
      // An expiry while already pending just re-sets the same flag.
      if (tmr == 10'(REFRESH_PERIOD - 1)) begin
        tmr     <= '0;
        pending <= 1'b1;
      end else begin
        tmr <= tmr + 10'd1;
        if (clear) pending <= 1'b0;
      end
      if (row_inc) row <= row + 7'd1;
    end
  end

endmodule

// File: rtl/dram_sequencer.sv
// Two-requester (video, CPU) sequencer for one 16K x 1 DRAM with optional RAS-only refresh.
// Refresh logic is built only when DRAM_SEQ_REFRESH_EN is defined.
module dram_sequencer
  import dram_seq_pkg::*;
#(
  parameter int CAS_CYCLES     = 1,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_dout,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_din,
  output logic              cpu_ack,
  output logic              cpu_dout,
  output logic [ROW_W-1:0]  dram_A,
  output logic              dram_nRAS,
  output logic              dram_nCAS,
  output logic              dram_nWRITE,
  output logic              dram_Din,
  input  logic              dram_Dout,
  output state_t            dbg_state
);

  state_t            state, state_nx;
  owner_t            owner;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, din_q;
  logic [1:0]        cnt;
  logic              cas_last;
  logic              rfsh_pending;
  logic [ROW_W-1:0]  rfsh_row;

`ifdef DRAM_SEQ_REFRESH_EN
  dram_refresh_timer #(.REFRESH_PERIOD(REFRESH_PERIOD)) u_refresh (
    .clk     (CLK),
    .rst_n   (nRESET),
    .clear   (state == IDLE && rfsh_pending),
    .row_inc (state == RROW && cnt == 2'd1),
    .pending (rfsh_pending),
    .row     (rfsh_row)
  );
`else
  assign rfsh_pending = 1'b0;
  assign rfsh_row     = '0;
`endif

  assign cas_last  = (cnt == 2'(CAS_CYCLES - 1));
  assign dbg_state = state;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (rfsh_pending)           state_nx = RROW;
        else if (vid_req || cpu_req) state_nx = ROW;
      end
      ROW:  state_nx = COL;
      COL:  state_nx = CAS;
      CAS:  if (cas_last) state_nx = DONE;
      DONE: state_nx = PRE;
      PRE:  state_nx = IDLE;
      RROW: if (cnt == 2'd1) state_nx = PRE;
      default: state_nx = IDLE;
    endcase
  end

  // cnt restarts on every state change, so it counts clocks spent in CAS/RROW.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      owner    <= OWN_NONE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      din_q    <= 1'b0;
      cnt      <= '0;
      vid_dout <= 1'b0;
      cpu_dout <= 1'b0;
    end else begin
      cnt <= (state_nx == state) ? cnt + 2'd1 : 2'd0;
      if (state == IDLE) begin
        if (rfsh_pending) begin
          owner <= OWN_NONE;
        end else if (vid_req) begin
          owner  <= OWN_VID;
          addr_q <= vid_addr;
          we_q   <= 1'b0;
          din_q  <= 1'b0;
        end else if (cpu_req) begin
          owner  <= OWN_CPU;
          addr_q <= cpu_addr;
          we_q   <= cpu_we;
          din_q  <= cpu_din;
        end
      end
      if (state == DONE) begin
        if (owner == OWN_VID)                 vid_dout <= dram_Dout;
        else if (owner == OWN_CPU && !we_q)   cpu_dout <= dram_Dout;
      end
    end
  end

  always_comb begin
    dram_A      = '0;
    dram_nRAS   = 1'b1;
    dram_nCAS   = 1'b1;
    dram_nWRITE = 1'b1;
    dram_Din    = 1'b0;
    case (state)
      ROW: begin
        dram_nRAS = 1'b0;
        dram_A    = addr_q[ADDR_W-1:COL_W];
      end
      COL, CAS: begin
        dram_nRAS   = 1'b0;
        dram_nCAS   = (state != CAS);
        dram_A      = addr_q[COL_W-1:0];
        dram_nWRITE = ~we_q;
        dram_Din    = we_q & din_q;
      end
      DONE: dram_A = addr_q[COL_W-1:0];
      RROW: begin
        dram_nRAS = 1'b0;
        dram_A    = rfsh_row;
      end
      default: ;
    endcase
  end

  assign vid_ack = (state == PRE) && (owner == OWN_VID);
  assign cpu_ack = (state == PRE) && (owner == OWN_CPU);

endmodule
